// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between the core's load/store port and the data memory.
//   req_valid/req_ready  request handshake; req_we, req_addr, req_size, req_wdata ride with it
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err ride with it
//   master: core side, slave: memory responder side
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master(
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave(
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word-organised RAM serving RV32I byte/half/word loads and stores.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    data_mem_if.slave: request in (valid/ready, we, addr, size, wdata),
//          response out (valid/ready, rdata, err)
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input logic        clk,
    input logic        reset,
    data_mem_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           lane_data, load_data, wdata_rep;
    logic [3:0]            be;
    assign req_err = (bus.req_size == 3'b011) || (bus.req_size[2:1] == 2'b11)
                  || (bus.req_size[1:0] == 2'b01 && bus.req_addr[0])
                  || (bus.req_size == 3'b010 && bus.req_addr[1:0] != 2'b00)
                  || (|(bus.req_addr >> (ADDR_WIDTH + 2)));
    assign idx       = addr_q[ADDR_WIDTH+1:2];
    assign lane_data = mem[idx] >> {addr_q[1:0], 3'b000};
    // size_q[2] selects zero extension (BU/HU); size_q[1:0] is the access width
    assign load_data = size_q[1:0] == 2'b00 ? {{24{~size_q[2] & lane_data[7]}}, lane_data[7:0]}
                     : size_q[1:0] == 2'b01 ? {{16{~size_q[2] & lane_data[15]}}, lane_data[15:0]}
                     : lane_data;
    // Store data is replicated across lanes so the byte enables alone pick the target lanes
    assign wdata_rep = size_q[1] ? wdata_q : size_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    assign be        = size_q[1] ? 4'b1111 : size_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011)
                     : 4'b0001 << addr_q[1:0];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                addr_d  = bus.req_addr[ADDR_WIDTH+1:0];
                size_d  = bus.req_size;
                wdata_d = bus.req_wdata;
                rdata_d = '0;
                err_d   = req_err;
                cnt_d   = '0;
                state_d = req_err ? RESP : (WAIT_CYCLES > 0 ? WAIT : ACCESS);
            end
            WAIT: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == 4'(WAIT_CYCLES - 1) ? ACCESS : WAIT;
            end
            ACCESS: begin
                rdata_d = we_q ? '0 : load_data;
                state_d = RESP;
            end
            default: begin
                // rsp_valid is registered, so it rises one edge after RESP is entered
                valid_d = ~(valid_q & bus.rsp_ready);
                state_d = valid_q & bus.rsp_ready ? IDLE : RESP;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && we_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
